spi_txn_scheduler: RTL and testbench
====================================

// Module: spi_txn_scheduler
// PURPOSE
//  Shares one SPI master engine between NREQ requesters, one transaction at a time.
//  Round-robin arbitration; issues a start pulse carrying the requester's 3-bit address.
//  Waits for the engine's done pulse, returns the received byte to the winning requester,
//  then enforces an idle gap before the next transaction. Aborts on a timeout.
// PARAMETERS
//  NREQ      4            number of requesters (2..8)
//  GAP_CYC   16           clk_50M cycles in GAP after each response; 0 = no gap
//  TO_CYC    100_000_000  clk_50M cycles allowed in WAIT before timeout (>=2)
//  TO_W      27           timeout counter width; must hold TO_CYC-1
// PORTS
//  clk_50M    in   1         system clock, all state on rising edge
//  reset      in   1         asynchronous, active-low; clears all state
//  req        in   NREQ      level request per requester; hold until own rsp_valid
//  req_addr   in   3*NREQ    requester i address at [3i+2:3i]
//  gnt        out  NREQ      one-hot owner of current transaction, 0 when none
//  rsp_valid  out  NREQ      one-cycle pulse to owner: rsp_data/rsp_err valid
//  rsp_data   out  8         byte received from engine (0 on timeout)
//  rsp_err    out  1         1 = transaction timed out
//  busy       out  1         1 in any state other than IDLE
//  spi_start  out  1         one-cycle pulse launching the engine
//  spi_tx     out  8         {5'b00000, addr} of owner, stable from spi_start to done
//  spi_done   in   1         one-cycle pulse from engine: transfer complete
//  spi_rx     in   8         engine received byte, valid with spi_done
// BEHAVIOUR
//  Reset (reset=0, any time, incl. mid-transaction): state=IDLE, all outputs 0,
//   rr pointer=0, counters=0. No response issued for an aborted transaction.
//  All outputs registered. States: IDLE, WAIT, RESP, GAP.
//  IDLE: if |req at edge k: winner = first set req scanning from rr pointer upward,
//   wrapping NREQ-1 -> 0. At edge k: gnt=onehot(winner), spi_tx={5'b0,addr}, spi_start=1,
//   timer=0, -> WAIT. req sampled only in IDLE.
//  WAIT: spi_start=0 after first cycle. Timer increments each cycle.
//   spi_done=1: rsp_data=spi_rx, rsp_err=0, rsp_valid[winner]=1, -> RESP.
//   else timer==TO_CYC-1: rsp_data=0, rsp_err=1, rsp_valid[winner]=1, -> RESP.
//   spi_done and timeout on same cycle: done wins.
//  RESP (exactly one cycle): next edge clears rsp_valid, gnt, busy stays 1;
//   rr pointer = winner+1 mod NREQ; -> GAP (or IDLE if GAP_CYC==0, busy=0).
//   rsp_data/rsp_err hold until next response.
//  GAP: counter counts GAP_CYC cycles, then -> IDLE. Requests wait.
//  Latency: req at edge k -> spi_start high cycle after edge k; done at edge m ->
//   rsp_valid high cycle after edge m; next spi_start no earlier than edge m+2+GAP_CYC.
//  Boundaries: spi_done outside WAIT ignored. Owner dropping req mid-transaction:
//   transaction completes, response still pulsed. Non-owner address changes ignored.
//   Single requester repeatedly asserting is served back-to-back (gap only).
//   Timer saturation not required; WAIT always exits by TO_CYC.
// TESTING
//  Single req[2], addr=3'b101: spi_start 1 cycle, spi_tx=8'h05; done with rx=8'hA5
//   -> rsp_valid=4'b0100 one cycle, rsp_data=8'hA5, rsp_err=0, gnt then 0.
//  req=4'b1111 held, 4 done pulses -> grant order 0,1,2,3,0; each spi_start separated
//   from previous rsp_valid by GAP_CYC+1 cycles.
//  TO_CYC=10, no spi_done -> rsp_valid to owner 10 cycles after spi_start,
//   rsp_err=1, rsp_data=8'h00; later spi_done in GAP/IDLE ignored.
//  spi_done on same cycle as timeout -> rsp_err=0, rsp_data=spi_rx.
//  reset=0 during WAIT -> all outputs 0 immediately; after release, req=4'b0010 gets
//   grant (pointer back at 0), no stale rsp_valid.
//  Owner drops req in WAIT; done with rx=8'h3C -> rsp_valid still pulsed, rsp_data=8'h3C.

Source files
------------

// File: rtl/spi_txn_scheduler_if.sv
// Bundle of every signal between the transaction scheduler, its requesters
// and the shared SPI master engine.
//   req        requester -> scheduler  level request per requester
//   req_addr   requester -> scheduler  3-bit address per requester, [3i+2:3i]
//   gnt        scheduler -> requester  one-hot owner of current transaction
//   rsp_valid  scheduler -> requester  one-cycle response pulse to owner
//   rsp_data   scheduler -> requester  received byte (0 on timeout)
//   rsp_err    scheduler -> requester  1 = transaction timed out
//   busy       scheduler -> requester  scheduler not idle
//   spi_start  scheduler -> engine     one-cycle launch pulse
//   spi_tx     scheduler -> engine     byte to send, {5'b0, owner addr}
//   spi_done   engine -> scheduler     one-cycle completion pulse
//   spi_rx     engine -> scheduler     received byte, valid with spi_done
// The master modport is the scheduler side; slave is the environment side.
interface spi_txn_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_addr;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              spi_start;
  logic [7:0]        spi_tx;
  logic              spi_done;
  logic [7:0]        spi_rx;

  modport master (
    input  req, req_addr, spi_done, spi_rx,
    output gnt, rsp_valid, rsp_data, rsp_err, busy, spi_start, spi_tx
  );

  modport slave (
    output req, req_addr, spi_done, spi_rx,
    input  gnt, rsp_valid, rsp_data, rsp_err, busy, spi_start, spi_tx
  );
endinterface

// File: rtl/spi_txn_scheduler.sv
// Shares one SPI master engine between NREQ requesters, one transaction at a
// time. Round-robin arbitration picks an owner, launches the engine with the
// owner's address, waits for completion (or a timeout), pulses the response
// back to the owner and then holds off for GAP_CYC cycles.
// Ports:
//   clk_50M  system clock, all state on its rising edge
//   reset    asynchronous, active-low; clears all state
//   bus      scheduler side (master modport) of spi_txn_scheduler_if
// All interface outputs are registered.
module spi_txn_scheduler #(
  parameter int NREQ    = 4,
  parameter int GAP_CYC = 16,
  parameter int TO_CYC  = 100_000_000,
  parameter int TO_W    = 27
) (
  input logic                 clk_50M,
  input logic                 reset,
  spi_txn_scheduler_if.master bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_next;
  logic [PTR_W-1:0] owner, owner_next;
  logic [TO_W-1:0]  timer, timer_next;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_next;

  logic [NREQ-1:0]  gnt_next, rsp_valid_next;
  logic [7:0]       rsp_data_next, spi_tx_next;
  logic             rsp_err_next, busy_next, spi_start_next;

  logic             found;
  logic [PTR_W-1:0] pick;
  logic [PTR_W:0]   scan_idx;

  // Round-robin search: walk offsets from highest to lowest so the requester
  // closest to rr_ptr (offset 0) is the last one written and therefore wins.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(o);
      if (scan_idx >= (PTR_W+1)'(NREQ)) begin
        scan_idx = scan_idx - (PTR_W+1)'(NREQ);
      end
      if (bus.req[scan_idx[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Next-state and next-output logic. Outputs default to holding their value
  // except the two single-cycle pulses, which default low.
  always_comb begin
    state_next     = state;
    rr_ptr_next    = rr_ptr;
    owner_next     = owner;
    timer_next     = timer;
    gap_cnt_next   = gap_cnt;
    gnt_next       = bus.gnt;
    rsp_valid_next = '0;
    rsp_data_next  = bus.rsp_data;
    rsp_err_next   = bus.rsp_err;
    spi_start_next = 1'b0;
    spi_tx_next    = bus.spi_tx;

    unique case (state)
      IDLE: begin
        if (found) begin
          owner_next     = pick;
          gnt_next       = NREQ'(1) << pick;
          spi_tx_next    = {5'b00000, bus.req_addr[pick*3 +: 3]};
          spi_start_next = 1'b1;
          timer_next     = '0;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        timer_next = timer + 1'b1;
        // A done pulse on the timeout cycle still counts as success.
        if (bus.spi_done) begin
          rsp_data_next  = bus.spi_rx;
          rsp_err_next   = 1'b0;
          rsp_valid_next = NREQ'(1) << owner;
          state_next     = RESP;
        end else if (timer == TO_W'(TO_CYC - 1)) begin
          rsp_data_next  = 8'h00;
          rsp_err_next   = 1'b1;
          rsp_valid_next = NREQ'(1) << owner;
          state_next     = RESP;
        end
      end
      RESP: begin
        gnt_next    = '0;
        rr_ptr_next = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
        if (GAP_CYC == 0) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = '0;
          state_next   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and registered outputs; reset abandons any transaction silently.
  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      timer         <= '0;
      gap_cnt       <= '0;
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.spi_start <= 1'b0;
      bus.spi_tx    <= '0;
    end else begin
      state         <= state_next;
      rr_ptr        <= rr_ptr_next;
      owner         <= owner_next;
      timer         <= timer_next;
      gap_cnt       <= gap_cnt_next;
      bus.gnt       <= gnt_next;
      bus.rsp_valid <= rsp_valid_next;
      bus.rsp_data  <= rsp_data_next;
      bus.rsp_err   <= rsp_err_next;
      bus.busy      <= busy_next;
      bus.spi_start <= spi_start_next;
      bus.spi_tx    <= spi_tx_next;
    end
  end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed testbench for spi_txn_scheduler with NREQ=4, GAP_CYC=3, TO_CYC=10.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, so each step() shows the result of the edge just taken.
module tb_spi_txn_scheduler;

  localparam int NREQ    = 4;
  localparam int GAP_CYC = 3;
  localparam int TO_CYC  = 10;
  localparam int TO_W    = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   cycle;

  spi_txn_scheduler_if #(.NREQ(NREQ)) bus ();

  spi_txn_scheduler #(
    .NREQ(NREQ), .GAP_CYC(GAP_CYC), .TO_CYC(TO_CYC), .TO_W(TO_W)
  ) dut (
    .clk_50M(clk),
    .reset  (reset_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.req       = '0;
    bus.req_addr  = '0;
    bus.spi_done  = 1'b0;
    bus.spi_rx    = '0;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rst_gnt: got %b expected 0000", bus.gnt); end
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rst_rsp_valid: got %b expected 0000", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_rsp_data: got %h expected 00", bus.rsp_data); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_err: got %b expected 0", bus.rsp_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.spi_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_spi_start: got %b expected 0", bus.spi_start); end
    checks++; if (bus.spi_tx !== 8'h00) begin errors++; $display("[TB] FAIL rst_spi_tx: got %h expected 00", bus.spi_tx); end
    // A stray done while idle must not produce a response.
    bus.spi_done = 1'b1;
    bus.spi_rx   = 8'hEE;
    step();
    bus.spi_done = 1'b0;
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL idle_done_valid: got %b expected 0000", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'h00) begin errors++; $display("[TB] FAIL idle_done_data: got %h expected 00", bus.rsp_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_done_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_single();
    do_reset();
    bus.req_addr = 12'b000_101_000_000;
    bus.req      = 4'b0100;
    step();
    checks++; if (bus.spi_start !== 1'b1) begin errors++; $display("[TB] FAIL single_start: got %b expected 1", bus.spi_start); end
    checks++; if (bus.spi_tx !== 8'h05) begin errors++; $display("[TB] FAIL single_tx: got %h expected 05", bus.spi_tx); end
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("[TB] FAIL single_gnt: got %b expected 0100", bus.gnt); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", bus.busy); end
    step();
    checks++; if (bus.spi_start !== 1'b0) begin errors++; $display("[TB] FAIL single_start_pulse: got %b expected 0", bus.spi_start); end
    checks++; if (bus.spi_tx !== 8'h05) begin errors++; $display("[TB] FAIL single_tx_hold: got %h expected 05", bus.spi_tx); end
    bus.spi_done = 1'b1;
    bus.spi_rx   = 8'hA5;
    step();
    bus.spi_done = 1'b0;
    bus.req      = 4'b0000;
    checks++; if (bus.rsp_valid !== 4'b0100) begin errors++; $display("[TB] FAIL single_rsp_valid: got %b expected 0100", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_rsp_data: got %h expected a5", bus.rsp_data); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp_err: got %b expected 0", bus.rsp_err); end
    step();
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL single_rsp_pulse: got %b expected 0000", bus.rsp_valid); end
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL single_gnt_clear: got %b expected 0000", bus.gnt); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_gap_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.rsp_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_data_hold: got %h expected a5", bus.rsp_data); end
    // GAP lasts GAP_CYC cycles from the RESP edge.
    repeat (GAP_CYC) step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_round_robin();
    int         start_cyc;
    int         rsp_cyc;
    int         n;
    logic [3:0] exp_g;
    logic [7:0] exp_rx;
    do_reset();
    bus.req_addr = 12'b100_011_010_001;
    bus.req      = 4'b1111;
    rsp_cyc      = 0;
    for (int t = 0; t < 5; t++) begin
      exp_g  = 4'b0001 << (t % 4);
      exp_rx = 8'h10 + 8'(t);
      n = 0;
      while (bus.spi_start !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      start_cyc = cycle;
      checks++; if (bus.gnt !== exp_g) begin errors++; $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", t, bus.gnt, exp_g); end
      checks++; if (bus.spi_tx !== 8'((t % 4) + 1)) begin errors++; $display("[TB] FAIL rr_tx[%0d]: got %h expected %h", t, bus.spi_tx, 8'((t % 4) + 1)); end
      // rsp_valid edge to next spi_start edge is GAP_CYC+2 edges,
      // i.e. GAP_CYC+1 quiet cycles between the two pulses.
      if (t > 0) begin
        checks++; if (start_cyc - rsp_cyc != GAP_CYC + 2) begin errors++; $display("[TB] FAIL rr_spacing[%0d]: got %0d expected %0d", t, start_cyc - rsp_cyc, GAP_CYC + 2); end
      end
      step();
      bus.spi_done = 1'b1;
      bus.spi_rx   = exp_rx;
      step();
      bus.spi_done = 1'b0;
      rsp_cyc = cycle;
      checks++; if (bus.rsp_valid !== exp_g) begin errors++; $display("[TB] FAIL rr_rsp_valid[%0d]: got %b expected %b", t, bus.rsp_valid, exp_g); end
      checks++; if (bus.rsp_data !== exp_rx) begin errors++; $display("[TB] FAIL rr_rsp_data[%0d]: got %h expected %h", t, bus.rsp_data, exp_rx); end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req_addr = 12'b000_000_000_110;
    bus.req      = 4'b0001;
    step();
    checks++; if (bus.spi_tx !== 8'h06) begin errors++; $display("[TB] FAIL to_first_tx: got %h expected 06", bus.spi_tx); end
    step();
    bus.spi_done = 1'b1;
    bus.spi_rx   = 8'hFF;
    step();
    bus.spi_done = 1'b0;
    checks++; if (bus.rsp_data !== 8'hFF) begin errors++; $display("[TB] FAIL to_first_data: got %h expected ff", bus.rsp_data); end
    // Same requester still asserting: served again right after the gap.
    repeat (GAP_CYC + 2) step();
    checks++; if (bus.spi_start !== 1'b1) begin errors++; $display("[TB] FAIL b2b_start: got %b expected 1", bus.spi_start); end
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL b2b_gnt: got %b expected 0001", bus.gnt); end
    repeat (TO_CYC - 1) step();
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL to_early: got %b expected 0000", bus.rsp_valid); end
    step();
    checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL to_rsp_valid: got %b expected 0001", bus.rsp_valid); end
    checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL to_rsp_err: got %b expected 1", bus.rsp_err); end
    checks++; if (bus.rsp_data !== 8'h00) begin errors++; $display("[TB] FAIL to_rsp_data: got %h expected 00", bus.rsp_data); end
    bus.req = 4'b0000;
    step();
    // Late done while in GAP.
    bus.spi_done = 1'b1;
    bus.spi_rx   = 8'h77;
    step();
    bus.spi_done = 1'b0;
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL gap_done_valid: got %b expected 0000", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'h00) begin errors++; $display("[TB] FAIL gap_done_data: got %h expected 00", bus.rsp_data); end
    checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL gap_done_err: got %b expected 1", bus.rsp_err); end
    repeat (GAP_CYC + 2) step();
    bus.spi_done = 1'b1;
    step();
    bus.spi_done = 1'b0;
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL idle_late_valid: got %b expected 0000", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_late_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_done_at_timeout();
    do_reset();
    bus.req_addr = 12'b000_000_011_000;
    bus.req      = 4'b0010;
    step();
    checks++; if (bus.spi_tx !== 8'h03) begin errors++; $display("[TB] FAIL tie_tx: got %h expected 03", bus.spi_tx); end
    repeat (TO_CYC - 1) step();
    bus.spi_done = 1'b1;
    bus.spi_rx   = 8'h5A;
    step();
    bus.spi_done = 1'b0;
    bus.req      = 4'b0000;
    checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("[TB] FAIL tie_valid: got %b expected 0010", bus.rsp_valid); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL tie_err: got %b expected 0", bus.rsp_err); end
    checks++; if (bus.rsp_data !== 8'h5A) begin errors++; $display("[TB] FAIL tie_data: got %h expected 5a", bus.rsp_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Serve requester 1 first so the pointer moves to 2.
    bus.req_addr = 12'b111_000_010_000;
    bus.req      = 4'b0010;
    step();
    step();
    bus.spi_done = 1'b1;
    bus.spi_rx   = 8'h11;
    step();
    bus.spi_done = 1'b0;
    bus.req      = 4'b0000;
    repeat (GAP_CYC + 2) step();
    bus.req = 4'b1000;
    step();
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("[TB] FAIL mid_gnt: got %b expected 1000", bus.gnt); end
    step();
    reset_n = 1'b0;
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL mid_rst_gnt: got %b expected 0000", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.spi_tx !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_tx: got %h expected 00", bus.spi_tx); end
    checks++; if (bus.rsp_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_data: got %h expected 00", bus.rsp_data); end
    // With the pointer back at 0, requester 1 beats requester 2.
    bus.req = 4'b0110;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("[TB] FAIL mid_regrant: got %b expected 0010", bus.gnt); end
    checks++; if (bus.spi_start !== 1'b1) begin errors++; $display("[TB] FAIL mid_restart: got %b expected 1", bus.spi_start); end
    repeat (2) step();
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL mid_stale_valid: got %b expected 0000", bus.rsp_valid); end
    bus.req = 4'b0000;
  endtask

  task automatic test_owner_drop();
    do_reset();
    bus.req_addr = 12'b000_000_000_010;
    bus.req      = 4'b0001;
    step();
    bus.req      = 4'b0000;
    bus.req_addr = 12'b111_111_111_111;
    step();
    checks++; if (bus.spi_tx !== 8'h02) begin errors++; $display("[TB] FAIL drop_tx_hold: got %h expected 02", bus.spi_tx); end
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL drop_gnt_hold: got %b expected 0001", bus.gnt); end
    bus.spi_done = 1'b1;
    bus.spi_rx   = 8'h3C;
    step();
    bus.spi_done = 1'b0;
    checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL drop_valid: got %b expected 0001", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'h3C) begin errors++; $display("[TB] FAIL drop_data: got %h expected 3c", bus.rsp_data); end
    step();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL drop_gnt_clear: got %b expected 0000", bus.gnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cycle  = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid();
    test_owner_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
